ysyx_22050854_wb_stage: RTL and testbench
=========================================

Name: ysyx_22050854_wb_stage

Overview:
Writeback stage between the memory stage and the integer register file. It accepts retiring instructions over a valid/ready handshake and buffers them in a 2-entry in-order skid buffer (head + skid). For loads it selects, extends and aligns the load data, then drives the register-file write port. It also exposes a forwarding lookup so decode can bypass values that have not yet been written.

Parameters:
PC_W, 64, width of the retiring PC carried for commit reporting
RF_AW, 5, register-file address width; x0 is address 0

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mem_valid  input  1  memory stage presents an instruction
mem_ready  output  1  stage can accept; registered, low while a skid entry is held
mem_pc  input  PC_W  PC of the instruction
mem_rd  input  RF_AW  destination register
mem_rd_wen  input  1  instruction writes rd
mem_is_load  input  1  select load data, not ALU result
mem_alu_result  input  64  ALU/CSR result
mem_load_raw  input  64  8-byte-aligned doubleword read from memory
mem_addr_low  input  3  load address bits [2:0]
mem_load_size  input  2  0=byte, 1=half, 2=word, 3=double
mem_load_unsigned  input  1  zero-extend instead of sign-extend
commit_ready  input  1  downstream (difftest/halt logic) allows retirement this cycle
rf_wen  output  1  register-file write enable
rf_waddr  output  RF_AW  register-file write address
rf_wdata  output  64  register-file write data
commit_valid  output  1  head entry retires this cycle
commit_pc  output  PC_W  PC of the retiring entry
misalign_err  output  1  retiring load was misaligned for its size
fwd_raddr  input  RF_AW  decode lookup address
fwd_hit  output  1  a buffered entry will write fwd_raddr
fwd_data  output  64  youngest matching buffered value

Behaviour:
- Reset: head_valid=0, skid_valid=0, mem_ready=0, rf_wen=0, commit_valid=0, misalign_err=0; rf_waddr, rf_wdata, commit_pc and fwd_data read 0. mem_ready rises on the first clk edge after rst_n deasserts. Reset mid-operation discards both entries, with no write.
- Accept: mem_valid && mem_ready at a clk edge. Extended data is computed at enqueue and stored as final wdata, together with pc, rd, wen and misalign.
- Load extend: shifted = mem_load_raw >> (8*mem_addr_low); truncate to 8/16/32/64 bits; sign- or zero-extend to 64. Size 3 ignores the unsigned flag. Non-load: wdata = mem_alu_result.
- Misalign: half with addr[0]=1, word with addr[1:0]!=0, or double with addr!=0. Data still uses the shift rule; high bytes are zero-filled before extension.
- Retire: occurs when head_valid && commit_ready. commit_valid=1, commit_pc=head.pc, misalign_err=head.misalign.
- rf_wen = retire && head.wen && head.rd!=0. rf_waddr and rf_wdata come from head. All retire outputs are combinational from head state.
- Latency: an accepted instruction can drive rf_wen in the cycle after acceptance at the earliest. The register-file write lands on the following edge.
- Placement on accept:
  - head empty, or head retiring with skid empty: into head.
  - head valid and not retiring: into skid.
- Skid promotion: when head retires and skid is valid, skid moves to head on the same edge.
- mem_ready next = !(skid_valid next). Accept and skid-occupied can never coincide.
- Order is strictly in-order. No entry is dropped or duplicated.
- Forwarding:
  - hit on skid (younger) has priority over head.
  - matching requires valid && wen && rd==fwd_raddr && rd!=0.
  - fwd_raddr=0 never hits.
  - no hit: fwd_hit=0, fwd_data=0.
- commit_ready held low: at most 2 entries are buffered and mem_ready=0 by the next cycle. Outputs stay stable with no writes.

Optional Feature:
Macro WB_PERF_CNT_EN.
- Defined: adds outputs perf_retired[63:0] and perf_stall[63:0]. Both reset to 0.
  - perf_retired increments on every retire.
  - perf_stall increments each cycle head_valid && !commit_ready.
  - Both wrap at 2^64.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Load byte: raw=0x8877665544332211, addr_low=7, size=0, signed, rd=5 -> one cycle later rf_wen=1, rf_waddr=5, rf_wdata=0xFFFFFFFFFFFFFF88. Same load with unsigned -> 0x0000000000000088.
- ALU op to x0: rd=0, wen=1, result=0x1234 -> commit_valid=1, rf_wen=0; fwd_raddr=0 gives fwd_hit=0.
- Back-pressure: commit_ready=0, stream three instructions rd=1,2,3 -> two accepted, then mem_ready=0. Raise commit_ready -> writes x1 then x2 then x3 on consecutive cycles; the third is accepted after the skid drains.
- Forward priority: head rd=7 data=0xA, skid rd=7 data=0xB, fwd_raddr=7 -> fwd_hit=1, fwd_data=0xB.
- Misaligned word: addr_low=2, size=2, raw=0x8877665544332211 -> rf_wdata=0x0000000066554433, misalign_err=1 in the retire cycle.
- Reset mid-stall: two entries buffered, pulse rst_n low asynchronously -> outputs are immediately 0, no rf_wen after release, and mem_ready=1 one edge later.

Source files
------------

// File: rtl/ysyx_22050854_wb_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_wb_stage
//
// Writeback stage between the memory stage and the integer register file.
// Retiring instructions arrive over a valid/ready handshake. They are held in
// a two-entry in-order buffer: "head" is the oldest entry and "skid" is the
// younger overflow entry. Load data is selected, aligned and extended when the
// instruction is accepted, so each entry stores final register-file data.
//
// Parameters
//   PC_W   width of the PC carried for commit reporting
//   RF_AW  register-file address width (x0 is address 0)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_valid/ready     handshake from the memory stage (ready is registered)
//   mem_pc, mem_rd, mem_rd_wen, mem_is_load, mem_alu_result,
//   mem_load_raw, mem_addr_low, mem_load_size, mem_load_unsigned
//                       retiring instruction payload
//   commit_ready        downstream allows the head entry to retire
//   rf_wen/waddr/wdata  register-file write port (combinational from head)
//   commit_valid/pc     commit report for the retiring head entry
//   misalign_err        retiring load was misaligned for its access size
//   fwd_raddr           decode bypass lookup address
//   fwd_hit/data        youngest buffered value that will write fwd_raddr
//
// Optional feature (macro WB_PERF_CNT_EN)
//   When defined, adds perf_retired[63:0] (retired instructions) and
//   perf_stall[63:0] (cycles with a valid head blocked by commit_ready).
//   When undefined, those ports and counters do not exist.
// ---------------------------------------------------------------------------
module ysyx_22050854_wb_stage #(
  parameter int PC_W  = 64,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  // memory-stage handshake and payload
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [PC_W-1:0]  mem_pc,
  input  logic [RF_AW-1:0] mem_rd,
  input  logic             mem_rd_wen,
  input  logic             mem_is_load,
  input  logic [63:0]      mem_alu_result,
  input  logic [63:0]      mem_load_raw,
  input  logic [2:0]       mem_addr_low,
  input  logic [1:0]       mem_load_size,
  input  logic             mem_load_unsigned,
  // retirement
  input  logic             commit_ready,
  output logic             rf_wen,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [63:0]      rf_wdata,
  output logic             commit_valid,
  output logic [PC_W-1:0]  commit_pc,
  output logic             misalign_err,
  // decode bypass
  input  logic [RF_AW-1:0] fwd_raddr,
  output logic             fwd_hit,
  output logic [63:0]      fwd_data
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]      perf_retired,
  output logic [63:0]      perf_stall
`endif
);

  // One buffered instruction, already reduced to what writeback needs.
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [RF_AW-1:0] rd;
    logic             wen;
    logic             misalign;
    logic [63:0]      wdata;
  } entry_t;

  entry_t head_q, skid_q;
  logic   head_valid, skid_valid;
  logic   ready_q;

  entry_t head_d, skid_d;
  logic   head_valid_d, skid_valid_d;

  entry_t new_entry;
  logic   accept;
  logic   retire;

  // -------------------------------------------------------------------------
  // Enqueue-side data path: load alignment, truncation, extension, misalign.
  // -------------------------------------------------------------------------
  logic [63:0] shifted;
  logic [63:0] load_data;
  logic        load_misalign;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    // Shifting right pulls the addressed byte to bit 0 and zero-fills the
    // top, so a misaligned access that runs off the doubleword sees zeros.
    shifted       = mem_load_raw >> {mem_addr_low, 3'b000};
    load_data     = shifted;
    load_misalign = 1'b0;
    case (mem_load_size)
      2'd0: begin
        load_data = mem_load_unsigned ? {56'd0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        load_data     = mem_load_unsigned ? {48'd0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
        load_misalign = mem_addr_low[0];
      end
      2'd2: begin
        load_data     = mem_load_unsigned ? {32'd0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
        load_misalign = (mem_addr_low[1:0] != 2'd0);
      end
      default: begin
        // Doubleword: no extension, the unsigned flag is irrelevant.
        load_data     = shifted;
        load_misalign = (mem_addr_low != 3'd0);
      end
    endcase
  end

  always_comb begin
    new_entry.pc       = mem_pc;
    new_entry.rd       = mem_rd;
    new_entry.wen      = mem_rd_wen;
    new_entry.misalign = mem_is_load && load_misalign;
    new_entry.wdata    = mem_is_load ? load_data : mem_alu_result;
  end

  // -------------------------------------------------------------------------
  // Handshake and retirement.
  // -------------------------------------------------------------------------
  // mem_ready is only ever high while the skid slot is empty, so an accepted
  // instruction always has somewhere to go.
  assign mem_ready = ready_q;
  assign accept    = mem_valid && ready_q;
  assign retire    = head_valid && commit_ready;

  // Retire outputs are driven straight from head state; the write lands on
  // the register file at the next edge.
  assign commit_valid = retire;
  assign commit_pc    = head_q.pc;
  assign misalign_err = retire && head_q.misalign;
  assign rf_wen       = retire && head_q.wen && (head_q.rd != '0);
  assign rf_waddr     = head_q.rd;
  assign rf_wdata     = head_q.wdata;

  // -------------------------------------------------------------------------
  // Buffer next-state.
  // -------------------------------------------------------------------------
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid;
    skid_valid_d = skid_valid;

    if (retire) begin
      if (skid_valid) begin
        // Promote the younger entry; accept cannot happen with skid full.
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        // Head leaves and a new arrival, if any, takes its place directly.
        head_valid_d = accept;
        if (accept) begin
          head_d = new_entry;
        end
      end
    end else if (accept) begin
      if (!head_valid) begin
        head_d       = new_entry;
        head_valid_d = 1'b1;
      end else begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the entry storage is reset too, not just the valid bits, because
  // the write-port and commit outputs are visible from head and must read 0
  // while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_valid <= head_valid_d;
      skid_valid <= skid_valid_d;
      ready_q    <= !skid_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding: the skid entry is younger, so it overrides a head match.
  // -------------------------------------------------------------------------
  logic head_match, skid_match;

  assign head_match = head_valid && head_q.wen && (head_q.rd == fwd_raddr) &&
                      (head_q.rd != '0);
  assign skid_match = skid_valid && skid_q.wen && (skid_q.rd == fwd_raddr) &&
                      (skid_q.rd != '0);

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 64'd0;
    if (skid_match) begin
      fwd_hit  = 1'b1;
      fwd_data = skid_q.wdata;
    end else if (head_match) begin
      fwd_hit  = 1'b1;
      fwd_data = head_q.wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Optional performance counters.
  // -------------------------------------------------------------------------
`ifdef WB_PERF_CNT_EN
  logic [63:0] retired_q, stall_q;

  // Both counters wrap naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 64'd0;
      stall_q   <= 64'd0;
    end else begin
      if (retire) begin
        retired_q <= retired_q + 64'd1;
      end
      if (head_valid && !commit_ready) begin
        stall_q <= stall_q + 64'd1;
      end
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ysyx_22050854_wb_stage.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ysyx_22050854_wb_stage.
//   1. reset values and the ready rise after release
//   2. table of single instructions (load extension, misalignment, x0 writes)
//   3. hand-written back-pressure, forwarding-priority and mid-stall reset
//   4. randomized traffic against a queue-based reference model
// ---------------------------------------------------------------------------
module tb_ysyx_22050854_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_pc;
  logic [4:0]  mem_rd;
  logic        mem_rd_wen;
  logic        mem_is_load;
  logic [63:0] mem_alu_result;
  logic [63:0] mem_load_raw;
  logic [2:0]  mem_addr_low;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned;
  logic        commit_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        misalign_err;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [63:0] fwd_data;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22050854_wb_stage #(.PC_W(64), .RF_AW(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_pc            (mem_pc),
    .mem_rd            (mem_rd),
    .mem_rd_wen        (mem_rd_wen),
    .mem_is_load       (mem_is_load),
    .mem_alu_result    (mem_alu_result),
    .mem_load_raw      (mem_load_raw),
    .mem_addr_low      (mem_addr_low),
    .mem_load_size     (mem_load_size),
    .mem_load_unsigned (mem_load_unsigned),
    .commit_ready      (commit_ready),
    .rf_wen            (rf_wen),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .commit_valid      (commit_valid),
    .commit_pc         (commit_pc),
    .misalign_err      (misalign_err),
    .fwd_raddr         (fwd_raddr),
    .fwd_hit           (fwd_hit),
    .fwd_data          (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid         = 1'b0;
    mem_pc            = 64'd0;
    mem_rd            = 5'd0;
    mem_rd_wen        = 1'b0;
    mem_is_load       = 1'b0;
    mem_alu_result    = 64'd0;
    mem_load_raw      = 64'd0;
    mem_addr_low      = 3'd0;
    mem_load_size     = 2'd0;
    mem_load_unsigned = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [63:0] val,
                           input logic [63:0] pc);
    mem_valid      = 1'b1;
    mem_pc         = pc;
    mem_rd         = rd;
    mem_rd_wen     = 1'b1;
    mem_is_load    = 1'b0;
    mem_alu_result = val;
  endtask

  // Wait (bounded) until the stage is ready to accept.
  task automatic wait_ready(input string name);
    int budget = 8;
    while (!mem_ready && budget > 0) begin
      step();
      budget--;
    end
    if (!mem_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: mem_ready never rose within budget", name);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: load result built byte by byte from the address rule.
  // -------------------------------------------------------------------------
  function automatic logic [63:0] model_load(input logic [63:0] raw,
                                             input int addr, input int size,
                                             input bit uns);
    int          nbytes = 1 << size;
    logic [63:0] v      = 64'd0;
    for (int i = 0; i < nbytes; i++) begin
      if (addr + i < 8) v[8*i +: 8] = raw[8*(addr+i) +: 8];
    end
    if (!uns && nbytes < 8 && v[8*nbytes-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*nbytes));
    return v;
  endfunction

  function automatic bit model_misalign(input int addr, input int size);
    return (addr % (1 << size)) != 0;
  endfunction

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    bit          wen;
    bit          mis;
    logic [63:0] data;
  } ment_t;

  ment_t model_q[$];
  bit    ready_m;

  // -------------------------------------------------------------------------
  // Single-instruction vectors.
  // -------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        is_load;
    logic [63:0] raw;
    logic [2:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        wen;
    logic        exp_wen;
    logic [63:0] exp_data;
    logic        exp_mis;
  } vec_t;

  localparam logic [63:0] RAW = 64'h8877_6655_4433_2211;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"lb_s_a7",   1'b1, RAW, 3'd7, 2'd0, 1'b0, 64'd0, 5'd5,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF88, 1'b0};
    vecs[1]  = '{"lb_u_a7",   1'b1, RAW, 3'd7, 2'd0, 1'b1, 64'd0, 5'd5,  1'b1, 1'b1, 64'h0000_0000_0000_0088, 1'b0};
    vecs[2]  = '{"lw_mis_a2", 1'b1, RAW, 3'd2, 2'd2, 1'b0, 64'd0, 5'd6,  1'b1, 1'b1, 64'h0000_0000_6655_4433, 1'b1};
    vecs[3]  = '{"lh_s_a6",   1'b1, RAW, 3'd6, 2'd1, 1'b0, 64'd0, 5'd7,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_8877, 1'b0};
    vecs[4]  = '{"lw_s_a4",   1'b1, RAW, 3'd4, 2'd2, 1'b0, 64'd0, 5'd8,  1'b1, 1'b1, 64'hFFFF_FFFF_8877_6655, 1'b0};
    vecs[5]  = '{"lw_u_a4",   1'b1, RAW, 3'd4, 2'd2, 1'b1, 64'd0, 5'd8,  1'b1, 1'b1, 64'h0000_0000_8877_6655, 1'b0};
    vecs[6]  = '{"ld_a0_u",   1'b1, RAW, 3'd0, 2'd3, 1'b1, 64'd0, 5'd9,  1'b1, 1'b1, 64'h8877_6655_4433_2211, 1'b0};
    vecs[7]  = '{"ld_mis_a3", 1'b1, RAW, 3'd3, 2'd3, 1'b0, 64'd0, 5'd10, 1'b1, 1'b1, 64'h0000_0088_7766_5544, 1'b1};
    vecs[8]  = '{"lh_mis_a1", 1'b1, RAW, 3'd1, 2'd1, 1'b0, 64'd0, 5'd11, 1'b1, 1'b1, 64'h0000_0000_0000_3322, 1'b1};
    vecs[9]  = '{"alu_x0",    1'b0, RAW, 3'd0, 2'd0, 1'b0, 64'h1234, 5'd0, 1'b1, 1'b0, 64'h1234, 1'b0};
    vecs[10] = '{"alu_nowen", 1'b0, RAW, 3'd0, 2'd0, 1'b0, 64'h55, 5'd9,  1'b0, 1'b0, 64'h55, 1'b0};
    vecs[11] = '{"alu_x31",   1'b0, RAW, 3'd5, 2'd2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 5'd31, 1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[12] = '{"lb_s_a5",   1'b1, RAW, 3'd5, 2'd0, 1'b0, 64'd0, 5'd12, 1'b1, 1'b1, 64'h0000_0000_0000_0066, 1'b0};
  end

  // -------------------------------------------------------------------------
  // Main sequence.
  // -------------------------------------------------------------------------
  initial begin
    rst_n        = 1'b0;
    commit_ready = 1'b0;
    fwd_raddr    = 5'd0;
    idle_inputs();

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_ready",    {63'd0, mem_ready},    64'd0);
    check("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    check("rst_rf_wen",       {63'd0, rf_wen},       64'd0);
    check("rst_rf_waddr",     {59'd0, rf_waddr},     64'd0);
    check("rst_rf_wdata",     rf_wdata,              64'd0);
    check("rst_commit_pc",    commit_pc,             64'd0);
    check("rst_misalign",     {63'd0, misalign_err}, 64'd0);
    check("rst_fwd_data",     fwd_data,              64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_still_low", {63'd0, mem_ready}, 64'd0);
    step();
    check("ready_after_edge", {63'd0, mem_ready}, 64'd1);

    // ---- single-instruction table ----
    commit_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      wait_ready(vecs[i].name);
      mem_valid         = 1'b1;
      mem_pc            = 64'h8000_0000 + 64'(4 * i);
      mem_rd            = vecs[i].rd;
      mem_rd_wen        = vecs[i].wen;
      mem_is_load       = vecs[i].is_load;
      mem_alu_result    = vecs[i].alu;
      mem_load_raw      = vecs[i].raw;
      mem_addr_low      = vecs[i].addr;
      mem_load_size     = vecs[i].size;
      mem_load_unsigned = vecs[i].uns;
      #1;
      check({vecs[i].name, "_no_early_wen"}, {63'd0, rf_wen}, 64'd0);
      step();
      idle_inputs();
      fwd_raddr = vecs[i].rd;
      #1;
      check({vecs[i].name, "_commit_valid"}, {63'd0, commit_valid}, 64'd1);
      check({vecs[i].name, "_commit_pc"}, commit_pc, 64'h8000_0000 + 64'(4 * i));
      check({vecs[i].name, "_rf_wen"}, {63'd0, rf_wen}, {63'd0, vecs[i].exp_wen});
      check({vecs[i].name, "_misalign"}, {63'd0, misalign_err}, {63'd0, vecs[i].exp_mis});
      check({vecs[i].name, "_fwd_hit"}, {63'd0, fwd_hit}, {63'd0, vecs[i].exp_wen});
      if (vecs[i].exp_wen) begin
        check({vecs[i].name, "_rf_waddr"}, {59'd0, rf_waddr}, {59'd0, vecs[i].rd});
        check({vecs[i].name, "_rf_wdata"}, rf_wdata, vecs[i].exp_data);
        check({vecs[i].name, "_fwd_data"}, fwd_data, vecs[i].exp_data);
      end else begin
        check({vecs[i].name, "_fwd_data0"}, fwd_data, 64'd0);
      end
      step();
      check({vecs[i].name, "_drained"}, {63'd0, commit_valid}, 64'd0);
    end

    // ---- back-pressure: three instructions with commit_ready low ----
    commit_ready = 1'b0;
    wait_ready("bp_start");
    drive_alu(5'd1, 64'h101, 64'h1000);
    step();
    drive_alu(5'd2, 64'h102, 64'h1004);
    step();
    drive_alu(5'd3, 64'h103, 64'h1008);
    fwd_raddr = 5'd2;
    #1;
    check("bp_ready_low",     {63'd0, mem_ready},    64'd0);
    check("bp_no_commit",     {63'd0, commit_valid}, 64'd0);
    check("bp_no_wen",        {63'd0, rf_wen},       64'd0);
    check("bp_fwd_hit_x2",    {63'd0, fwd_hit},      64'd1);
    check("bp_fwd_data_x2",   fwd_data,              64'h102);
    step();
    check("bp_ready_still_low", {63'd0, mem_ready},  64'd0);
    check("bp_stable_no_wen",   {63'd0, rf_wen},     64'd0);
    commit_ready = 1'b1;
    #1;
    check("bp_wr1_wen",   {63'd0, rf_wen},   64'd1);
    check("bp_wr1_addr",  {59'd0, rf_waddr}, 64'd1);
    check("bp_wr1_data",  rf_wdata,          64'h101);
    step();
    check("bp_ready_after_drain", {63'd0, mem_ready}, 64'd1);
    check("bp_wr2_wen",   {63'd0, rf_wen},   64'd1);
    check("bp_wr2_addr",  {59'd0, rf_waddr}, 64'd2);
    step();
    idle_inputs();
    #1;
    check("bp_wr3_wen",   {63'd0, rf_wen},   64'd1);
    check("bp_wr3_addr",  {59'd0, rf_waddr}, 64'd3);
    check("bp_wr3_pc",    commit_pc,         64'h1008);
    step();
    check("bp_empty",     {63'd0, commit_valid}, 64'd0);

    // ---- forward priority: skid (younger) beats head ----
    commit_ready = 1'b0;
    wait_ready("fp_start");
    drive_alu(5'd7, 64'hA, 64'h2000);
    step();
    drive_alu(5'd7, 64'hB, 64'h2004);
    step();
    idle_inputs();
    fwd_raddr = 5'd7;
    #1;
    check("fp_hit",  {63'd0, fwd_hit}, 64'd1);
    check("fp_data", fwd_data,         64'hB);
    fwd_raddr = 5'd8;
    #1;
    check("fp_miss_hit",  {63'd0, fwd_hit}, 64'd0);
    check("fp_miss_data", fwd_data,         64'd0);
    fwd_raddr = 5'd7;

    // ---- asynchronous reset with two entries buffered ----
    rst_n = 1'b0;
    #1;
    check("mr_fwd_hit",   {63'd0, fwd_hit},   64'd0);
    check("mr_fwd_data",  fwd_data,           64'd0);
    check("mr_ready",     {63'd0, mem_ready}, 64'd0);
    check("mr_waddr",     {59'd0, rf_waddr},  64'd0);
    check("mr_wdata",     rf_wdata,           64'd0);
    check("mr_commit_pc", commit_pc,          64'd0);
    commit_ready = 1'b1;
    #1;
    check("mr_no_commit", {63'd0, commit_valid}, 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("mr_rel_no_wen", {63'd0, rf_wen},    64'd0);
    check("mr_rel_ready0", {63'd0, mem_ready}, 64'd0);
    step();
    check("mr_ready1",     {63'd0, mem_ready}, 64'd1);
    check("mr_no_wen_1",   {63'd0, rf_wen},    64'd0);
    step();
    check("mr_no_wen_2",   {63'd0, rf_wen},    64'd0);

    // ---- randomized traffic against the reference model ----
    rst_n = 1'b0;
    idle_inputs();
    commit_ready = 1'b0;
    #2;
    model_q.delete();
    ready_m = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ment_t e;
      bit    acc, ret, exp_hit;
      logic [63:0] exp_fwd;
      int    cr_pct;

      cr_pct            = ((cyc / 150) % 2 == 1) ? 15 : 85;
      mem_valid         = ($urandom_range(0, 99) < 60);
      mem_pc            = {$urandom, $urandom};
      mem_rd            = 5'($urandom_range(0, 7));
      mem_rd_wen        = ($urandom_range(0, 99) < 80);
      mem_is_load       = $urandom_range(0, 1) == 1;
      mem_alu_result    = {$urandom, $urandom};
      mem_load_raw      = {$urandom, $urandom};
      mem_addr_low      = 3'($urandom_range(0, 7));
      mem_load_size     = 2'($urandom_range(0, 3));
      mem_load_unsigned = $urandom_range(0, 1) == 1;
      commit_ready      = ($urandom_range(0, 99) < cr_pct);
      fwd_raddr         = 5'($urandom_range(0, 7));
      #1;

      ret = (model_q.size() > 0) && commit_ready;
      acc = mem_valid && ready_m;

      check("rnd_mem_ready",    {63'd0, mem_ready},    {63'd0, ready_m});
      check("rnd_commit_valid", {63'd0, commit_valid}, {63'd0, ret});
      if (ret) begin
        check("rnd_rf_wen", {63'd0, rf_wen},
              {63'd0, model_q[0].wen && model_q[0].rd != 5'd0});
        check("rnd_commit_pc", commit_pc, model_q[0].pc);
        check("rnd_misalign", {63'd0, misalign_err}, {63'd0, model_q[0].mis});
        if (model_q[0].wen && model_q[0].rd != 5'd0) begin
          check("rnd_rf_waddr", {59'd0, rf_waddr}, {59'd0, model_q[0].rd});
          check("rnd_rf_wdata", rf_wdata, model_q[0].data);
        end
      end else begin
        check("rnd_rf_wen_idle", {63'd0, rf_wen}, 64'd0);
      end

      exp_hit = 1'b0;
      exp_fwd = 64'd0;
      for (int k = model_q.size() - 1; k >= 0; k--) begin
        if (!exp_hit && model_q[k].wen && model_q[k].rd == fwd_raddr &&
            model_q[k].rd != 5'd0) begin
          exp_hit = 1'b1;
          exp_fwd = model_q[k].data;
        end
      end
      check("rnd_fwd_hit",  {63'd0, fwd_hit}, {63'd0, exp_hit});
      check("rnd_fwd_data", fwd_data,         exp_fwd);

      e.pc   = mem_pc;
      e.rd   = mem_rd;
      e.wen  = mem_rd_wen;
      e.mis  = mem_is_load && model_misalign(int'(mem_addr_low), int'(mem_load_size));
      e.data = mem_is_load ? model_load(mem_load_raw, int'(mem_addr_low),
                                        int'(mem_load_size), mem_load_unsigned)
                           : mem_alu_result;

      step();
      if (ret) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
      if (model_q.size() > 2) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd_occupancy: model holds %0d entries, limit 2", model_q.size());
        model_q.delete();
      end
      ready_m = (model_q.size() < 2);
    end

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got %0d checks expected completion", n_tests);
    $fatal(1, "timeout");
  end

endmodule
